geofence_driver: RTL and testbench

- Initiator side of the geofence point-stream interface.
- Fetches point sets (1 target + 6 fence vertices) from a synchronous point ROM and streams them on X/Y to a geofence evaluator, one point per cycle.
- Owns the evaluator's reset, waits for its valid, and writes each is_inside verdict to a result memory.
- Prefetches the next set while the evaluator computes, so the stream restarts with no bubble.

---
 rtl/geofence_driver.sv | 229 ++++++++++++++++++++++
 tb/tb_geofence_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/geofence_driver.sv
// Geofence point-stream initiator: fetches 7-point sets from a synchronous ROM,
// streams them to the evaluator one per cycle and records each verdict.
module geofence_driver #(
  parameter int NSET    = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [19:0]       rom_data,
  output logic              gf_reset,
  output logic [9:0]        X,
  output logic [9:0]        Y,
  input  logic              valid,
  input  logic              is_inside,
  output logic              res_we,
  output logic [7:0]        res_addr,
  output logic              res_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int WCW = $clog2(TIMEOUT + 1);

  if (NSET < 1 || NSET > 255 || 7 * NSET > (1 << ADDR_W)) begin : g_param_chk
    $error("geofence_driver: NSET must be 1..255 and 7*NSET <= 2**ADDR_W");
  end

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_WAIT, S_FINISH, S_ERR} state_t;
  state_t state_q, state_d;

  logic              fetch_on_q, fetch_on_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] nbase_q, nbase_d;
  logic              full_q, full_d;
  logic [2:0]        pidx_q, pidx_d;
  logic [7:0]        set_q, set_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic              valid_q;
  logic [19:0]       xy_q, xy_d;
  logic              gfr_q, gfr_d;
  logic              we_q, we_d;
  logic [7:0]        raddr_q, raddr_d;
  logic              rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [19:0]       pbuf_q [7];

  logic cap_we, cap_last, full_eff, vrise, last_set, wto, enter_err;

  // fcnt counts edges since the first address was issued; capture lags issue by one
  assign cap_we    = fetch_on_q && (fcnt_q != 3'd0);
  assign cap_last  = fetch_on_q && (fcnt_q == 3'd7);
  assign full_eff  = full_q || cap_last;
  assign vrise     = valid && !valid_q;
  assign last_set  = (set_q == 8'(NSET - 1));
  assign wto       = (wcnt_q == WCW'(TIMEOUT - 1));
  assign enter_err = (state_d == S_ERR) && (state_q != S_ERR);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FILL;
      S_FILL:   if (cap_last) state_d = S_STREAM;
      S_STREAM: if (pidx_q == 3'd6) state_d = S_WAIT;
      S_WAIT: begin
        if (vrise)    state_d = last_set ? S_FINISH : (full_eff ? S_STREAM : S_ERR);
        else if (wto) state_d = S_ERR;
      end
      S_FINISH: state_d = S_IDLE;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_on_d = fetch_on_q;
    fcnt_d     = fcnt_q;
    addr_d     = addr_q;
    nbase_d    = nbase_q;
    full_d     = full_q;
    pidx_d     = pidx_q;
    set_d      = set_q;
    wcnt_d     = wcnt_q;
    xy_d       = xy_q;
    gfr_d      = gfr_q;
    we_d       = 1'b0;
    raddr_d    = raddr_q;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;

    if (fetch_on_q) begin
      fcnt_d = fcnt_q + 3'd1;
      if (fcnt_q < 3'd6) addr_d = addr_q + ADDR_W'(1);
      if (cap_last) begin
        fetch_on_d = 1'b0;
        full_d     = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          set_d      = 8'd0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          full_d     = 1'b0;
          fetch_on_d = 1'b1;
          fcnt_d     = 3'd0;
          addr_d     = '0;
          nbase_d    = ADDR_W'(7);
        end
      end
      S_FILL: begin
        if (cap_last) begin
          gfr_d  = 1'b0;
          xy_d   = pbuf_q[0];
          pidx_d = 3'd1;
        end
      end
      S_STREAM: begin
        xy_d   = pbuf_q[pidx_q];
        pidx_d = pidx_q + 3'd1;
        if (pidx_q == 3'd6) begin
          full_d = 1'b0;
          wcnt_d = '0;
          if (!last_set) begin
            fetch_on_d = 1'b1;
            fcnt_d     = 3'd0;
            addr_d     = nbase_q;
            nbase_d    = nbase_q + ADDR_W'(7);
          end
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + WCW'(1);
        if (vrise) begin
          we_d    = 1'b1;
          raddr_d = set_q;
          rdata_d = is_inside;
          if (!last_set && full_eff) begin
            xy_d   = pbuf_q[0];
            set_d  = set_q + 8'd1;
            pidx_d = 3'd1;
          end
        end
      end
      S_FINISH: begin
        gfr_d  = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase

    if (enter_err) begin
      err_d      = 1'b1;
      gfr_d      = 1'b1;
      busy_d     = 1'b0;
      fetch_on_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_on_q <= 1'b0;
      fcnt_q     <= 3'd0;
      addr_q     <= '0;
      nbase_q    <= '0;
      full_q     <= 1'b0;
      pidx_q     <= 3'd0;
      set_q      <= 8'd0;
      wcnt_q     <= '0;
      valid_q    <= 1'b0;
      xy_q       <= 20'd0;
      gfr_q      <= 1'b1;
      we_q       <= 1'b0;
      raddr_q    <= 8'd0;
      rdata_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      fetch_on_q <= fetch_on_d;
      fcnt_q     <= fcnt_d;
      addr_q     <= addr_d;
      nbase_q    <= nbase_d;
      full_q     <= full_d;
      pidx_q     <= pidx_d;
      set_q      <= set_d;
      wcnt_q     <= wcnt_d;
      valid_q    <= valid;
      xy_q       <= xy_d;
      gfr_q      <= gfr_d;
      we_q       <= we_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_we) pbuf_q[fcnt_q - 3'd1] <= rom_data;
  end

  assign rom_addr = addr_q;
  assign gf_reset = gfr_q;
  assign X        = xy_q[19:10];
  assign Y        = xy_q[9:0];
  assign res_we   = we_q;
  assign res_addr = raddr_q;
  assign res_data = rdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
endmodule

// File: tb/tb_geofence_driver.sv
// Bench for geofence_driver: ROM model, behavioural evaluator checking every
// streamed point, and a result scoreboard.
module tb_geofence_driver;
  localparam int NS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rom_addr;
  logic [19:0] rom_data = 20'd0;
  logic       gf_reset;
  logic [9:0] X, Y;
  logic       valid = 1'b0;
  logic       is_inside = 1'b0;
  logic       res_we;
  logic [7:0] res_addr;
  logic       res_data;
  logic       busy, done, err;

  geofence_driver #(.NSET(NS), .ADDR_W(8), .TIMEOUT(20)) u_dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .gf_reset(gf_reset), .X(X), .Y(Y), .valid(valid), .is_inside(is_inside),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [19:0] rom [256];
  bit          exp_v [NS] = '{1'b1, 1'b0, 1'b1};
  logic [8:0]  sb_q [$];
  int n_vec = 0, n_err = 0;
  int cyc = 0, p6_cyc = 0;
  int ev_p = 0, ev_set = 0, ev_vph = 0, ev_cd = -1, ev_dly = 8;
  bit ev_strm = 1'b0, ev_never = 1'b0, ev_v = 1'b0;
  int ex [7], ey [7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [19:0] pt(input int x, input int y);
    return {10'(x), 10'(y)};
  endfunction

  function automatic bit inside_poly(input int px [7], input int py [7]);
    bit  c = 1'b0;
    real xc;
    for (int i = 1; i <= 6; i++) begin
      int j = (i == 6) ? 1 : i + 1;
      if ((py[i] > py[0]) != (py[j] > py[0])) begin
        xc = real'(px[i]) + real'(px[j] - px[i]) * real'(py[0] - py[i]) / real'(py[j] - py[i]);
        if (real'(px[0]) < xc) c = ~c;
      end
    end
    return c;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: address seen in one cycle returns data in the next
  initial begin
    logic [7:0] a1;
    a1 = 8'd0;
    forever begin
      @(negedge clk);
      rom_data = rom[a1];
      a1 = rom_addr;
    end
  end

  // Behavioural evaluator: collects 7 points, waits ev_dly, raises valid for 2 cycles
  initial begin
    forever begin
      @(negedge clk);
      if (gf_reset) begin
        ev_p = 0; ev_set = 0; ev_vph = 0; ev_cd = -1; ev_strm = 1'b1; valid = 1'b0;
      end else begin
        if (ev_vph == 2) begin
          valid = 1'b0; ev_vph = 0;
        end else if (ev_vph == 1) begin
          ev_vph = 2;
          if (ev_set + 1 < NS) begin
            ev_set++; ev_p = 0; ev_strm = 1'b1;
          end
        end
        if (ev_strm) begin
          chk($sformatf("pt s%0d p%0d", ev_set, ev_p), 32'({X, Y}), 32'(rom[7*ev_set+ev_p]));
          ex[ev_p] = int'(X); ey[ev_p] = int'(Y);
          ev_p++;
          if (ev_p == 7) begin
            ev_strm = 1'b0;
            ev_v = inside_poly(ex, ey);
            p6_cyc = cyc;
            ev_cd = ev_never ? -1 : ev_dly;
          end
        end else if (ev_cd == 0) begin
          valid = 1'b1; is_inside = ev_v; ev_vph = 1; ev_cd = -1;
        end else if (ev_cd > 0) begin
          ev_cd--;
        end
      end
    end
  end

  // Result monitor
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (res_we) begin
        if (sb_q.size() == 0) chk("res_we_unexpected", 32'(res_we), 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("res", 32'({res_addr, res_data}), 32'(e));
        end
      end
    end
  end

  task automatic sb_push(input int nsets);
    for (int s = 0; s < nsets; s++) sb_q.push_back({8'(s), exp_v[s]});
  endtask

  task automatic chk_rst();
    chk("rst_gf_reset", 32'(gf_reset), 32'd1);
    chk("rst_xy", 32'({X, Y}), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_res", 32'({res_we, res_addr, res_data}), 32'd0);
    chk("rst_flags", 32'({busy, done, err}), 32'd0);
  endtask

  task automatic run_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 1) chk("start_busy_done", 32'({busy, done}), 32'b10);
      if (k <= 7) chk($sformatf("fill_addr%0d", k - 1), 32'(rom_addr), 32'(k - 1));
      chk($sformatf("gf_reset_lat%0d", k), 32'(gf_reset), (k == 9) ? 32'd0 : 32'd1);
      if (k < 9) @(negedge clk);
    end
  endtask

  task automatic wait_sig(input string tag, input int lim, input bit use_err);
    int i;
    for (i = 0; i < lim && !(use_err ? err : done); i++) @(negedge clk);
    chk(tag, 32'(use_err ? err : done), 32'd1);
  endtask

  initial begin
    int hx [6] = '{0, 100, 150, 100, 0, 0};
    int hy [6] = '{0, 0, 50, 100, 100, 50};
    for (int w = 0; w < 256; w++) rom[w] = 20'(w * 4099 + 17);
    rom[0]  = pt(50, 50);
    rom[7]  = pt(500, 500);
    rom[14] = pt(60, 40);
    for (int i = 0; i < 6; i++) begin
      rom[1+i]  = pt(hx[i], hy[i]);
      rom[8+i]  = pt(hx[i], hy[i]);
      rom[15+i] = pt(hx[(i+2)%6], hy[(i+2)%6]);
    end

    repeat (3) @(negedge clk);
    chk_rst();
    reset = 1'b0;
    @(negedge clk);
    chk_rst();

    // Full 3-set run; a start pulse mid-run must be ignored
    sb_push(NS);
    run_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_sig("run1_done", 400, 1'b0);
    chk("run1_end_flags", 32'({busy, err, gf_reset}), 32'b001);
    chk("run1_sb_empty", 32'(sb_q.size()), 32'd0);

    // Second run, aborted by reset while streaming set 1, then restarted
    sb_push(NS);
    run_start();
    chk("run2_done_clr", 32'(done), 32'd0);
    for (int i = 0; i < 200 && !(ev_set == 1 && ev_p == 3); i++) @(negedge clk);
    chk("run2_reach_set1", 32'(ev_set), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_rst();
    sb_q.delete();
    repeat (30) @(negedge clk);
    chk("abort_idle", 32'({busy, done, err, gf_reset}), 32'b0001);
    sb_push(NS);
    run_start();
    wait_sig("run3_done", 400, 1'b0);
    chk("run3_sb_empty", 32'(sb_q.size()), 32'd0);

    // Late valid: arrives before the prefetch completes
    ev_dly = 2;
    sb_push(1);
    run_start();
    wait_sig("late_err", 200, 1'b1);
    chk("late_flags", 32'({gf_reset, busy}), 32'b10);
    chk("late_sb_empty", 32'(sb_q.size()), 32'd0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_sticky", 32'({err, busy, gf_reset}), 32'b101);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk_rst();

    // Evaluator never answers: timeout 20 cycles after point 6
    ev_dly = 8;
    ev_never = 1'b1;
    run_start();
    wait_sig("to_err", 200, 1'b1);
    chk("to_latency", 32'(cyc - p6_cyc), 32'd20);
    chk("to_flags", 32'({gf_reset, busy}), 32'b10);
    repeat (5) @(negedge clk);
    chk("to_sb_empty", 32'(sb_q.size()), 32'd0);
    reset = 1'b1; @(negedge clk); reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
